// File: rtl/bsg_link_sched_pkg.sv
// Shared types and sizing helpers for the upstream link scheduler.
// Provides the FSM state enum plus flit-count and counter-width functions.
package bsg_link_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic int flits_lp_f(int w, int cw);
    return w / cw;
  endfunction

  function automatic int cnt_w_f(int credits);
    return $clog2(credits + 1);
  endfunction

  // index width that stays >= 1 even for a single entry
  function automatic int idx_w_f(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_link_credit_counter.sv
// Per-channel credit counter: +D on token, -1 on flit, saturating at credits_p.
// Ports: clk, rst_n, token_i, dec_i, cnt_o (live count), overflow_o (sticky).
module bsg_link_credit_counter
  import bsg_link_sched_pkg::*;
#(
  parameter int credits_p          = 16,
  parameter int token_decimation_p = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           token_i,
  input  logic                           dec_i,
  output logic [cnt_w_f(credits_p)-1:0]  cnt_o,
  output logic                           overflow_o
);

  localparam int cw_lp = cnt_w_f(credits_p);

  logic [cw_lp-1:0] cnt_q;
  logic             ovf_q;
  logic [31:0]      sum;

  // wide sum so token + debit can be judged before saturation
  always_comb begin
    sum = 32'(cnt_q)
        + (token_i ? 32'(token_decimation_p) : 32'd0)
        - (dec_i ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= cw_lp'(credits_p);
      ovf_q <= 1'b0;
    end else if (sum > 32'(credits_p)) begin
      cnt_q <= cw_lp'(credits_p);
      ovf_q <= 1'b1;
    end else begin
      cnt_q <= sum[cw_lp-1:0];
    end
  end

  assign cnt_o      = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/bsg_link_upstream_channel_sched.sv
// Upstream link scheduler: round-robin channel pick by credit, low-flit-first
// serialisation. Ports: core valid/ready/data in, per-channel flit valid/data/ready,
// token pulses, live credit counts, sticky overflow flags, busy.
module bsg_link_upstream_channel_sched
  import bsg_link_sched_pkg::*;
#(
  parameter int num_channels_p     = 2,
  parameter int width_p            = 64,
  parameter int channel_width_p    = 32,
  parameter int credits_p          = 16,
  parameter int token_decimation_p = 8
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         core_valid_i,
  input  logic [width_p-1:0]                           core_data_i,
  output logic                                         core_ready_o,
  input  logic [num_channels_p-1:0]                    token_i,
  output logic [num_channels_p-1:0]                    ch_valid_o,
  output logic [num_channels_p*channel_width_p-1:0]    ch_data_o,
  input  logic [num_channels_p-1:0]                    ch_ready_i,
  output logic [num_channels_p*cnt_w_f(credits_p)-1:0] credit_cnt_o,
  output logic [num_channels_p-1:0]                    credit_overflow_o,
  output logic                                         busy_o
);

  localparam int flits_lp = flits_lp_f(width_p, channel_width_p);
  localparam int cw_lp    = cnt_w_f(credits_p);
  localparam int gw_lp    = idx_w_f(num_channels_p);
  localparam int iw_lp    = idx_w_f(flits_lp);

  state_e                 state_q;
  logic [gw_lp-1:0]       grant_q;
  logic [gw_lp-1:0]       last_q;
  logic [width_p-1:0]     pkt_q;
  logic [iw_lp-1:0]       idx_q;

  logic [num_channels_p-1:0] elig;
  logic [num_channels_p-1:0] dec;
  logic [gw_lp-1:0]          grant_n;
  logic                      any_elig;
  logic [channel_width_p-1:0] flit;
  logic                      send;

  assign send = (state_q == SEND);

  for (genvar c = 0; c < num_channels_p; c++) begin : g_cred
    assign elig[c] = 32'(credit_cnt_o[c*cw_lp +: cw_lp]) >= 32'(flits_lp);
    assign dec[c]  = send && (grant_q == gw_lp'(c)) && ch_ready_i[c];

    bsg_link_credit_counter #(
      .credits_p          (credits_p),
      .token_decimation_p (token_decimation_p)
    ) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .token_i    (token_i[c]),
      .dec_i      (dec[c]),
      .cnt_o      (credit_cnt_o[c*cw_lp +: cw_lp]),
      .overflow_o (credit_overflow_o[c])
    );
  end

  // first eligible channel after last_q, wrapping
  always_comb begin
    int c;
    c        = 0;
    grant_n  = last_q;
    any_elig = 1'b0;
    for (int i = 1; i <= num_channels_p; i++) begin
      c = (int'(last_q) + i) % num_channels_p;
      if (!any_elig && elig[c]) begin
        any_elig = 1'b1;
        grant_n  = gw_lp'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= gw_lp'(num_channels_p - 1);
      pkt_q   <= '0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (core_valid_i && any_elig) begin
            pkt_q   <= core_data_i;
            grant_q <= grant_n;
            last_q  <= grant_n;
            idx_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (ch_ready_i[grant_q]) begin
            if (32'(idx_q) == 32'(flits_lp - 1))
              state_q <= IDLE;
            else
              idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign flit = pkt_q[int'(idx_q)*channel_width_p +: channel_width_p];

  always_comb begin
    ch_valid_o = '0;
    ch_data_o  = '0;
    for (int c = 0; c < num_channels_p; c++) begin
      if (send && grant_q == gw_lp'(c)) begin
        ch_valid_o[c] = 1'b1;
        ch_data_o[c*channel_width_p +: channel_width_p] = flit;
      end
    end
  end

  assign core_ready_o = (state_q == IDLE) && any_elig;
  assign busy_o       = send;

endmodule

// File: tb/tb_bsg_link_upstream_channel_sched.sv
// Directed bench for the upstream link scheduler with a per-cycle packet-level
// model compare plus hand-computed literal expectations.
module tb_bsg_link_upstream_channel_sched;

  localparam int N = 2;
  localparam int W = 64;
  localparam int CHW = 32;
  localparam int CRED = 16;
  localparam int D = 8;
  localparam int F = W / CHW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           core_valid_i = 1'b0;
  logic [W-1:0]   core_data_i = '0;
  logic           core_ready_o;
  logic [N-1:0]   token_i = '0;
  logic [N-1:0]   ch_valid_o;
  logic [N*CHW-1:0] ch_data_o;
  logic [N-1:0]   ch_ready_i = '1;
  logic [N*5-1:0] credit_cnt_o;
  logic [N-1:0]   credit_overflow_o;
  logic           busy_o;

  int n_pass = 0;
  int n_total = 0;

  bsg_link_upstream_channel_sched dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .core_valid_i      (core_valid_i),
    .core_data_i       (core_data_i),
    .core_ready_o      (core_ready_o),
    .token_i           (token_i),
    .ch_valid_o        (ch_valid_o),
    .ch_data_o         (ch_data_o),
    .ch_ready_i        (ch_ready_i),
    .credit_cnt_o      (credit_cnt_o),
    .credit_overflow_o (credit_overflow_o),
    .busy_o            (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [79:0] got, logic [79:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    else
      n_pass++;
  endtask

  // packet-level model: credits, in-flight packet, round-robin pointer
  int        m_cred[N] = '{CRED, CRED};
  bit        m_ovf[N]  = '{0, 0};
  bit        m_busy = 0;
  int        m_g = 0;
  int        m_last = N - 1;
  int        m_idx = 0;
  logic [W-1:0] m_pkt = '0;

  function automatic int pick(output bit found);
    int c;
    found = 0;
    for (int k = 1; k <= N; k++) begin
      c = (m_last + k) % N;
      if (m_cred[c] >= F) begin
        found = 1;
        return c;
      end
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int deb[N];
    int v;
    int g;
    bit found;
    if (!rst_n) begin
      for (int c = 0; c < N; c++) begin
        m_cred[c] = CRED;
        m_ovf[c] = 0;
      end
      m_busy = 0;
      m_last = N - 1;
      m_idx = 0;
    end else begin
      for (int c = 0; c < N; c++) deb[c] = 0;
      if (m_busy) begin
        if (ch_ready_i[m_g]) begin
          deb[m_g] = 1;
          m_idx++;
          if (m_idx == F) m_busy = 0;
        end
      end else begin
        g = pick(found);
        if (found && core_valid_i) begin
          m_busy = 1;
          m_g = g;
          m_last = g;
          m_pkt = core_data_i;
          m_idx = 0;
        end
      end
      for (int c = 0; c < N; c++) begin
        v = m_cred[c] + (token_i[c] ? D : 0) - deb[c];
        if (v > CRED) begin
          v = CRED;
          m_ovf[c] = 1;
        end
        m_cred[c] = v;
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0]   ev;
    logic [N*CHW-1:0] ed;
    logic           er;
    logic [N*5-1:0] ec;
    logic [N-1:0]   eo;
    bit             found;
    int             g;
    ev = '0;
    ed = '0;
    if (m_busy) begin
      ev[m_g] = 1'b1;
      ed[m_g*CHW +: CHW] = m_pkt[m_idx*CHW +: CHW];
    end
    g = pick(found);
    er = !m_busy && found;
    for (int c = 0; c < N; c++) begin
      ec[c*5 +: 5] = 5'(m_cred[c]);
      eo[c] = m_ovf[c];
    end
    check("model", {ch_valid_o, ch_data_o, core_ready_o, credit_cnt_o,
                    credit_overflow_o, busy_o},
                   {ev, ed, er, ec, eo, m_busy});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    core_valid_i = 1'b1;
    core_data_i = 64'hDEADBEEF_01234567;
    ch_ready_i = 2'b11;
    repeat (3) step();
    rst_n = 1'b1;

    // reset state with valid already high
    @(negedge clk);
    check("t1_cred", 80'(credit_cnt_o), 80'({5'd16, 5'd16}));
    check("t1_ready", 80'(core_ready_o), 80'(1));
    check("t1_valid", 80'(ch_valid_o), 80'(0));

    // first packet on ch0, low flit first
    step();
    core_data_i = 64'hCAFEF00D_55AA33CC;
    @(negedge clk);
    check("t2_v0", 80'(ch_valid_o), 80'(2'b01));
    check("t2_f0", 80'(ch_data_o[31:0]), 80'(32'h01234567));
    step();
    @(negedge clk);
    check("t2_f1", 80'(ch_data_o[31:0]), 80'(32'hDEADBEEF));
    step();
    @(negedge clk);
    check("t2_c0", 80'(credit_cnt_o[4:0]), 80'(14));
    step();
    @(negedge clk);
    check("t2_v1", 80'(ch_valid_o), 80'(2'b10));
    check("t2_f1lo", 80'(ch_data_o[63:32]), 80'(32'h55AA33CC));
    step();
    step();
    @(negedge clk);
    check("t2_c1", 80'(credit_cnt_o[9:5]), 80'(14));

    // drain all credit
    repeat (50) begin
      core_data_i = {$urandom, $urandom};
      step();
    end
    @(negedge clk);
    check("t3_cred0", 80'(credit_cnt_o), 80'(0));
    check("t3_ready0", 80'(core_ready_o), 80'(0));
    core_data_i = 64'h11112222_33334444;
    token_i = 2'b01;
    step();
    token_i = 2'b00;
    @(negedge clk);
    check("t3_c8", 80'(credit_cnt_o[4:0]), 80'(8));
    check("t3_ready1", 80'(core_ready_o), 80'(1));
    step();
    core_valid_i = 1'b0;
    @(negedge clk);
    check("t3_ch0", 80'(ch_valid_o), 80'(2'b01));
    step();
    step();

    // token coinciding with flit debit, then overflow
    core_valid_i = 1'b1;
    core_data_i = 64'hA5A5A5A5_5A5A5A5A;
    step();
    core_valid_i = 1'b0;
    token_i = 2'b01;
    step();
    token_i = 2'b00;
    @(negedge clk);
    check("t5_c13", 80'(credit_cnt_o[4:0]), 80'(13));
    step();
    token_i = 2'b01;
    step();
    token_i = 2'b00;
    @(negedge clk);
    check("t5_c16", 80'(credit_cnt_o[4:0]), 80'(16));
    check("t5_ovf", 80'(credit_overflow_o), 80'(2'b01));

    // channel stall
    ch_ready_i = 2'b00;
    core_valid_i = 1'b1;
    core_data_i = 64'h0BAD0BAD_C0FFEE00;
    step();
    core_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_stall", {ch_valid_o, ch_data_o[31:0], credit_cnt_o[4:0], busy_o},
            80'({2'b01, 32'hC0FFEE00, 5'd16, 1'b1}));
      step();
    end
    ch_ready_i = 2'b11;
    step();
    step();
    @(negedge clk);
    check("t4_done", 80'({credit_cnt_o[4:0], credit_overflow_o, busy_o}),
          80'({5'd14, 2'b01, 1'b0}));

    // refill ch1, start a packet there, reset mid-send
    token_i = 2'b10;
    step();
    step();
    token_i = 2'b00;
    core_valid_i = 1'b1;
    core_data_i = 64'h76543210_FEDCBA98;
    step();
    @(negedge clk);
    check("t6_ch1", 80'(ch_valid_o), 80'(2'b10));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst", 80'({ch_valid_o, busy_o, credit_cnt_o, credit_overflow_o}),
          80'({2'b00, 1'b0, 5'd16, 5'd16, 2'b00}));
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_ready", 80'(core_ready_o), 80'(1));
    step();
    core_valid_i = 1'b0;
    @(negedge clk);
    check("t6_ch0", 80'({ch_valid_o, ch_data_o[31:0]}), 80'({2'b01, 32'hFEDCBA98}));
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
